// File: rtl/dm_ctl.sv
// Data memory for the Forth core: byte-lane writes, Req/Ready/RValid handshake,
// registered read path with optional wait states, range check and sequential clear.
module dm_ctl #(
  parameter int unsigned DW           = 16,
  parameter int unsigned DEPTH_LOG2   = 10,
  parameter int unsigned AW           = 16,
  parameter int unsigned WAIT         = 0,
  parameter int unsigned CLEAR_ON_RST = 1
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Req,
  input  logic            We,
  input  logic [DW/8-1:0] ByteEn,
  input  logic [AW-1:0]   MemAddr,
  input  logic [DW-1:0]   WData,
  output logic            Ready,
  output logic [DW-1:0]   RData,
  output logic            RValid,
  output logic            AddrErr,
  output logic            Busy
);

  localparam int unsigned NB      = DW / 8;
  localparam int unsigned BS      = (NB > 1) ? $clog2(NB) : 0;
  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned IDX_TOP = BS + DEPTH_LOG2;
  localparam int unsigned WCW     = 3;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_RWAIT = 2'd2;

  localparam logic [WCW-1:0] WAIT_LAST = WCW'((WAIT == 0) ? 0 : WAIT - 1);

  logic [DW-1:0]         mem [DEPTH];
  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [DEPTH_LOG2-1:0] clr_ptr;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_oor;
  logic [WCW-1:0]        wcnt;

  logic [DEPTH_LOG2-1:0] idx_c;
  logic                  oor_c;
  logic                  accept_c;
  logic                  wr_acc_c;
  logic                  rd_acc_c;
  logic                  wait_done_c;
  logic                  rv_set_c;
  logic [DEPTH_LOG2-1:0] smp_idx_c;
  logic                  smp_oor_c;

  // Address decode: low BS bits select a byte within the word and are ignored
  assign idx_c = MemAddr[IDX_TOP-1:BS];
  assign oor_c = (AW > IDX_TOP) ? (|(MemAddr >> IDX_TOP)) : 1'b0;

  assign Ready = (state == S_IDLE) && !Rst;
  assign Busy  = (state == S_CLEAR) || Rst;

  assign accept_c    = Req && Ready;
  assign wr_acc_c    = accept_c && We && !oor_c;
  assign rd_acc_c    = accept_c && !We;
  assign wait_done_c = (state == S_RWAIT) && (wcnt == WAIT_LAST);
  assign rv_set_c    = (rd_acc_c && (WAIT == 0)) || wait_done_c;

  // With wait states the read sources the captured address, otherwise the live one
  assign smp_idx_c = (state == S_RWAIT) ? rd_idx : idx_c;
  assign smp_oor_c = (state == S_RWAIT) ? rd_oor : oor_c;

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if ((CLEAR_ON_RST == 0) || (&clr_ptr)) state_nxt = S_IDLE;
      S_IDLE:  if (rd_acc_c && (WAIT != 0)) state_nxt = S_RWAIT;
      S_RWAIT: if (wait_done_c) state_nxt = S_IDLE;
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      clr_ptr <= '0;
      RData   <= '0;
      RValid  <= 1'b0;
      AddrErr <= 1'b0;
      rd_idx  <= '0;
      rd_oor  <= 1'b0;
      wcnt    <= '0;
    end else begin
      if (state == S_CLEAR) clr_ptr <= clr_ptr + 1'b1;
      RValid  <= rv_set_c;
      AddrErr <= accept_c && oor_c;
      if (rv_set_c) RData <= smp_oor_c ? '0 : mem[smp_idx_c];
      if (rd_acc_c) begin
        rd_idx <= idx_c;
        rd_oor <= oor_c;
        wcnt   <= '0;
      end else if (state == S_RWAIT) begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end

  // Single write port shared by the clear sweep and lane-masked stores
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if ((state == S_CLEAR) && (CLEAR_ON_RST != 0)) begin
        mem[clr_ptr] <= '0;
      end else if (wr_acc_c) begin
        for (int i = 0; i < NB; i++) begin
          if (ByteEn[i]) mem[idx_c][8*i +: 8] <= WData[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_ctl.sv
// Directed bench for dm_ctl: two instances (WAIT=0 and WAIT=2) driven by the same inputs.
module tb_dm_ctl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req;
  logic        We;
  logic [1:0]  ByteEn;
  logic [15:0] MemAddr;
  logic [15:0] WData;

  logic        ready0, rvalid0, err0, busy0;
  logic [15:0] rdata0;
  logic        ready2, rvalid2, err2, busy2;
  logic [15:0] rdata2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  dm_ctl #(.DW(16), .DEPTH_LOG2(10), .AW(16), .WAIT(0), .CLEAR_ON_RST(1)) u_dut0 (
    .Clk(Clk), .Rst(Rst), .Req(Req), .We(We), .ByteEn(ByteEn), .MemAddr(MemAddr),
    .WData(WData), .Ready(ready0), .RData(rdata0), .RValid(rvalid0),
    .AddrErr(err0), .Busy(busy0)
  );

  dm_ctl #(.DW(16), .DEPTH_LOG2(10), .AW(16), .WAIT(2), .CLEAR_ON_RST(1)) u_dut2 (
    .Clk(Clk), .Rst(Rst), .Req(Req), .We(We), .ByteEn(ByteEn), .MemAddr(MemAddr),
    .WData(WData), .Ready(ready2), .RData(rdata2), .RValid(rvalid2),
    .AddrErr(err2), .Busy(busy2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be,
                    input logic exp_err);
    Req = 1'b1; We = 1'b1; MemAddr = a; WData = d; ByteEn = be;
    chk("wr_ready0", 16'(ready0), 16'd1);
    chk("wr_ready2", 16'(ready2), 16'd1);
    tick();
    Req = 1'b0; We = 1'b0;
    chk("wr_err0", 16'(err0), 16'(exp_err));
    chk("wr_err2", 16'(err2), 16'(exp_err));
    chk("wr_norv0", 16'(rvalid0), 16'd0);
    if (!exp_err && be != 2'b00) $display("*%h <= %h", a, d);
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp0, input logic [15:0] exp2,
                    input logic exp_err);
    Req = 1'b1; We = 1'b0; MemAddr = a;
    chk("rd_ready0", 16'(ready0), 16'd1);
    chk("rd_ready2", 16'(ready2), 16'd1);
    tick();
    Req = 1'b0;
    chk("rd_rv0_n1", 16'(rvalid0), 16'd1);
    chk("rd_data0", rdata0, exp0);
    chk("rd_err0", 16'(err0), 16'(exp_err));
    chk("rd_err2", 16'(err2), 16'(exp_err));
    chk("rd_ready0_n1", 16'(ready0), 16'd1);
    chk("rd_ready2_n1", 16'(ready2), 16'd0);
    chk("rd_rv2_n1", 16'(rvalid2), 16'd0);
    tick();
    chk("rd_rv0_n2", 16'(rvalid0), 16'd0);
    chk("rd_ready2_n2", 16'(ready2), 16'd0);
    chk("rd_rv2_n2", 16'(rvalid2), 16'd0);
    chk("rd_err2_n2", 16'(err2), 16'd0);
    tick();
    chk("rd_rv2_n3", 16'(rvalid2), 16'd1);
    chk("rd_data2", rdata2, exp2);
    chk("rd_ready2_n3", 16'(ready2), 16'd1);
    tick();
    chk("rd_rv2_n4", 16'(rvalid2), 16'd0);
    chk("rd_hold2", rdata2, exp2);
  endtask

  task automatic count_clear(input string tag);
    int cnt;
    cnt = 0;
    while (busy0 && cnt < 3000) begin
      cnt++;
      tick();
    end
    chk(tag, 16'(cnt), 16'd1024);
    chk("clr_ready0", 16'(ready0), 16'd1);
    chk("clr_ready2", 16'(ready2), 16'd1);
    chk("clr_busy2", 16'(busy2), 16'd0);
  endtask

  task automatic pulse_reset();
    Rst = 1'b1;
    tick();
    tick();
    chk("rst_ready0", 16'(ready0), 16'd0);
    chk("rst_busy2", 16'(busy2), 16'd1);
    chk("rst_rvalid2", 16'(rvalid2), 16'd0);
    chk("rst_rdata0", rdata0, 16'h0000);
    Rst = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; Req = 1'b0; We = 1'b0; ByteEn = 2'b00; MemAddr = '0; WData = '0;
    tick();
    tick();
    chk("init_ready0", 16'(ready0), 16'd0);
    chk("init_ready2", 16'(ready2), 16'd0);
    chk("init_busy0", 16'(busy0), 16'd1);
    chk("init_rdata2", rdata2, 16'h0000);
    chk("init_rvalid0", 16'(rvalid0), 16'd0);
    chk("init_err0", 16'(err0), 16'd0);
    Rst = 1'b0;
    count_clear("init_clear_cycles");

    // Reset clears a preloaded word
    wr(16'h000A, 16'hBEEF, 2'b11, 1'b0);
    rd(16'h000A, 16'hBEEF, 16'hBEEF, 1'b0);
    pulse_reset();
    count_clear("t1_clear_cycles");
    rd(16'h000A, 16'h0000, 16'h0000, 1'b0);

    // Byte lanes, including an all-lanes-off no-op
    wr(16'h0010, 16'h1234, 2'b11, 1'b0);
    wr(16'h0010, 16'hAB00, 2'b10, 1'b0);
    wr(16'h0010, 16'hFFFF, 2'b00, 1'b0);
    rd(16'h0010, 16'hAB34, 16'hAB34, 1'b0);

    // Wait states: a write request during RWAIT is ignored by the WAIT=2 instance only
    Req = 1'b1; We = 1'b0; MemAddr = 16'h0010;
    tick();
    We = 1'b1; MemAddr = 16'h0030; WData = 16'h7777; ByteEn = 2'b11;
    chk("t3_ready2_n1", 16'(ready2), 16'd0);
    chk("t3_rv0_n1", 16'(rvalid0), 16'd1);
    chk("t3_data0", rdata0, 16'hAB34);
    tick();
    Req = 1'b0; We = 1'b0;
    chk("t3_ready2_n2", 16'(ready2), 16'd0);
    chk("t3_rv2_n2", 16'(rvalid2), 16'd0);
    tick();
    chk("t3_rv2_n3", 16'(rvalid2), 16'd1);
    chk("t3_data2", rdata2, 16'hAB34);
    chk("t3_ready2_n3", 16'(ready2), 16'd1);
    tick();
    chk("t3_rv2_n4", 16'(rvalid2), 16'd0);
    rd(16'h0030, 16'h7777, 16'h0000, 1'b0);

    // Range check: 0x0800 must not alias word 0
    wr(16'h0000, 16'h1111, 2'b11, 1'b0);
    wr(16'h0800, 16'h5555, 2'b11, 1'b1);
    rd(16'h0000, 16'h1111, 16'h1111, 1'b0);
    rd(16'h0800, 16'h0000, 16'h0000, 1'b1);

    // Back-to-back write then read of the same word
    wr(16'h0020, 16'h00FF, 2'b11, 1'b0);
    rd(16'h0020, 16'h00FF, 16'h00FF, 1'b0);

    // Reset mid-clear restarts the sweep
    wr(16'h0708, 16'h0001, 2'b11, 1'b0);
    rd(16'h0708, 16'h0001, 16'h0001, 1'b0);
    pulse_reset();
    repeat (500) tick();
    chk("t6_busy_mid", 16'(busy0), 16'd1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    count_clear("t6_clear_cycles");
    rd(16'h0708, 16'h0000, 16'h0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
